// File: rtl/decoder_3x8_pulse_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the 3-to-8 pulse decoder:
//   - dec_state_t : two-state FSM encoding (IDLE / DRIVE), 1 bit
//   - DEC_IN_W    : code width (3)
//   - DEC_OUT_W   : one-hot output width (8)
//   - onehot3()   : binary code -> one-hot vector
//   - odd_par_ok(): odd-parity check over {code, code_par}
// -----------------------------------------------------------------------------
package decoder_pkg;

  localparam int DEC_IN_W  = 3;
  localparam int DEC_OUT_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } dec_state_t;

  // Binary code to one-hot select line.
  function automatic logic [DEC_OUT_W-1:0] onehot3(input logic [DEC_IN_W-1:0] c);
    logic [DEC_OUT_W-1:0] one;
    one = 8'h01;
    return one << c;
  endfunction

  // True when {c, p} carries an odd number of ones.
  function automatic logic odd_par_ok(input logic [DEC_IN_W-1:0] c, input logic p);
    return ^{c, p};
  endfunction

endpackage

// File: rtl/decoder_3x8_pulse_hold_counter.sv
// -----------------------------------------------------------------------------
// hold_counter
// Loadable HOLD_W-bit down-counter used to time the decoder output pulse.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load count with load_val (has priority over dec)
//   load_val    : value loaded on load
//   dec         : decrement by one; saturates at zero
//   count       : current count (registered)
//   zero        : count == 0
// -----------------------------------------------------------------------------
module hold_counter #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              dec,
  output logic [HOLD_W-1:0] count,
  output logic              zero
);

  logic [HOLD_W-1:0] count_r;

  // Count register: load, saturating decrement, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {HOLD_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {HOLD_W{1'b0}})) begin
      count_r <= count_r - {{(HOLD_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {HOLD_W{1'b0}});

endmodule

// File: rtl/decoder_3x8_pulse.sv
// -----------------------------------------------------------------------------
// decoder_3x8_pulse
// Registered 3-to-8 one-hot decoder with valid/ready input handshake and a
// programmable hold time. An accepted code drives y[code] for max(hold,1)
// cycles; done marks the last of those cycles.
// Optional feature macro: DEC_PARITY_EN (adds code_par input and err output;
// odd parity over {code, code_par}; a bad code is consumed and flagged
// instead of driven).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : gates acceptance of new codes only
//   in_valid   : source presents code/hold
//   in_ready   : combinational, (state == IDLE) && en
//   code       : 3-bit binary code
//   code_par   : parity bit (DEC_PARITY_EN only)
//   err        : one-cycle parity error pulse (DEC_PARITY_EN only)
//   hold       : pulse length in cycles, 0 treated as 1
//   y          : registered one-hot output
//   y_valid    : registered, high while y != 0
//   busy       : registered, high in DRIVE
//   done       : registered, high on the last DRIVE cycle
// -----------------------------------------------------------------------------
module decoder_3x8_pulse
  import decoder_pkg::*;
#(
  parameter int HOLD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DEC_IN_W-1:0]  code,
`ifdef DEC_PARITY_EN
  input  logic                 code_par,
  output logic                 err,
`endif
  input  logic [HOLD_W-1:0]    hold,
  output logic [DEC_OUT_W-1:0] y,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 done
);

  dec_state_t           state_r, state_nxt_s;
  logic [DEC_OUT_W-1:0] y_r, y_nxt_s;
  logic                 y_valid_r;
  logic                 busy_r;
  logic                 done_r, done_nxt_s;
  logic                 accept_s;
  logic                 par_ok_s;
  logic                 load_s;
  logic                 dec_s;
  logic [HOLD_W-1:0]    load_val_s;
  logic [HOLD_W-1:0]    cnt_s;
  logic                 cnt_zero_s;

  assign in_ready = (state_r == ST_IDLE) && en;
  assign accept_s = in_valid && in_ready;

  // hold == 0 behaves like hold == 1, so the loaded value never exceeds 2^W-2.
  assign load_val_s = (hold == {HOLD_W{1'b0}}) ? {HOLD_W{1'b0}}
                                               : (hold - {{(HOLD_W-1){1'b0}}, 1'b1});

`ifdef DEC_PARITY_EN
  logic err_r;

  assign par_ok_s = odd_par_ok(code, code_par);

  // Parity error pulse, one cycle after a rejected accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= accept_s && !par_ok_s;
    end
  end

  assign err = err_r;
`else
  assign par_ok_s = 1'b1;
`endif

  hold_counter #(
    .HOLD_W (HOLD_W)
  ) u_hold_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (load_val_s),
    .dec      (dec_s),
    .count    (cnt_s),
    .zero     (cnt_zero_s)
  );

  // Next-state, next-output and counter control.
  always_comb begin
    state_nxt_s = state_r;
    y_nxt_s     = y_r;
    done_nxt_s  = 1'b0;
    load_s      = 1'b0;
    dec_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && par_ok_s) begin
          state_nxt_s = ST_DRIVE;
          y_nxt_s     = onehot3(code);
          load_s      = 1'b1;
          // A one-cycle pulse is already on its last cycle when it starts.
          done_nxt_s  = (load_val_s == {HOLD_W{1'b0}});
        end else begin
          state_nxt_s = ST_IDLE;
          y_nxt_s     = {DEC_OUT_W{1'b0}};
        end
      end
      ST_DRIVE: begin
        if (cnt_zero_s) begin
          state_nxt_s = ST_IDLE;
          y_nxt_s     = {DEC_OUT_W{1'b0}};
        end else begin
          dec_s      = 1'b1;
          // Counter reaches zero on this edge: next cycle is the last one.
          done_nxt_s = (cnt_s == {{(HOLD_W-1){1'b0}}, 1'b1});
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        y_nxt_s     = {DEC_OUT_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      y_r       <= {DEC_OUT_W{1'b0}};
      y_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      y_r       <= y_nxt_s;
      y_valid_r <= (y_nxt_s != {DEC_OUT_W{1'b0}});
      busy_r    <= (state_nxt_s == ST_DRIVE);
      done_r    <= done_nxt_s;
    end
  end

  assign y       = y_r;
  assign y_valid = y_valid_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_decoder_3x8_pulse.sv
// -----------------------------------------------------------------------------
// tb_decoder_3x8_pulse
// Directed, table-driven bench for decoder_3x8_pulse. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_decoder_3x8_pulse;

  localparam int HOLD_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  code;
  logic        code_par;
  logic [3:0]  hold;
  logic [7:0]  y;
  logic        y_valid;
  logic        busy;
  logic        done;
`ifdef DEC_PARITY_EN
  logic        err;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] code;
    logic [3:0] hold;
    logic [7:0] exp_y;
    int         exp_len;
  } vec_t;

  vec_t tbl[12];

  decoder_3x8_pulse #(.HOLD_W(HOLD_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .code     (code),
`ifdef DEC_PARITY_EN
    .code_par (code_par),
    .err      (err),
`endif
    .hold     (hold),
    .y        (y),
    .y_valid  (y_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a code with correct odd parity.
  task automatic set_code(input logic [2:0] c);
    code     = c;
    code_par = ~(^c);
  endtask

  // Called on a falling edge in IDLE: one-cycle valid, then follow the pulse.
  task automatic run_pulse(input vec_t v, input string tag);
    set_code(v.code);
    hold     = v.hold;
    in_valid = 1'b1;
    chk({tag, " ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= v.exp_len; k++) begin
      chk({tag, " y"}, y, v.exp_y);
      chk({tag, " y_valid"}, y_valid, 1);
      chk({tag, " busy"}, busy, 1);
      chk({tag, " done"}, done, (k == v.exp_len) ? 1 : 0);
      @(negedge clk);
    end
    chk({tag, " y after"}, y, 0);
    chk({tag, " busy after"}, busy, 0);
    chk({tag, " done after"}, done, 0);
    chk({tag, " ready after"}, in_ready, 1);
  endtask

  initial begin
    logic [7:0] bp_y [5];
    logic       bp_d [5];
    logic       seen_done;

    tbl[0]  = '{3'd3, 4'd4,  8'h08, 4};
    tbl[1]  = '{3'd0, 4'd0,  8'h01, 1};
    tbl[2]  = '{3'd1, 4'd0,  8'h02, 1};
    tbl[3]  = '{3'd2, 4'd0,  8'h04, 1};
    tbl[4]  = '{3'd3, 4'd0,  8'h08, 1};
    tbl[5]  = '{3'd4, 4'd0,  8'h10, 1};
    tbl[6]  = '{3'd5, 4'd0,  8'h20, 1};
    tbl[7]  = '{3'd6, 4'd0,  8'h40, 1};
    tbl[8]  = '{3'd7, 4'd0,  8'h80, 1};
    tbl[9]  = '{3'd2, 4'd1,  8'h04, 1};
    tbl[10] = '{3'd7, 4'd15, 8'h80, 15};
    tbl[11] = '{3'd4, 4'd2,  8'h10, 2};

    bp_y[0] = 8'h20; bp_y[1] = 8'h20; bp_y[2] = 8'h00; bp_y[3] = 8'h40; bp_y[4] = 8'h40;
    bp_d[0] = 1'b0;  bp_d[1] = 1'b1;  bp_d[2] = 1'b0;  bp_d[3] = 1'b0;  bp_d[4] = 1'b1;

    // Reset with random code/hold/valid; en low so in_ready must read 0.
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; code = 3'd0; code_par = 1'b0; hold = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      code     = 3'($urandom_range(0, 7));
      code_par = 1'($urandom_range(0, 1));
      hold     = 4'($urandom_range(0, 15));
      #1;
      chk("rst y", y, 0);
      chk("rst y_valid", y_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst ready", in_ready, 0);
`ifdef DEC_PARITY_EN
      chk("rst err", err, 0);
`endif
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    en       = 1'b1;
    @(negedge clk);
    chk("post-rst ready", in_ready, 1);
    chk("post-rst y", y, 0);

    // Table: single code, hold-zero sweep, hold 1, max hold.
    for (int i = 0; i < 12; i++) begin
      run_pulse(tbl[i], $sformatf("vec%0d", i));
    end

    // Backpressure: valid held high, code 5 then 6, hold 2.
    set_code(3'd5);
    hold     = 4'd2;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) set_code(3'd6);
      chk($sformatf("bp y c%0d", c + 1), y, bp_y[c]);
      chk($sformatf("bp done c%0d", c + 1), done, bp_d[c]);
      if (c == 3) in_valid = 1'b0;
    end
    @(negedge clk);
    chk("bp y end", y, 0);
    chk("bp ready end", in_ready, 1);

    // Enable dropped mid-DRIVE: pulse completes, next code waits for en.
    set_code(3'd1);
    hold     = 4'd3;
    in_valid = 1'b1;
    @(negedge clk);
    en = 1'b0;
    set_code(3'd4);
    hold = 4'd1;
    chk("en y c1", y, 8'h02);
    @(negedge clk);
    chk("en y c2", y, 8'h02);
    @(negedge clk);
    chk("en y c3", y, 8'h02);
    chk("en done c3", done, 1);
    @(negedge clk);
    chk("en y c4", y, 0);
    chk("en ready c4", in_ready, 0);
    @(negedge clk);
    chk("en y c5", y, 0);
    chk("en busy c5", busy, 0);
    en = 1'b1;
    #1;
    chk("en ready c5", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("en y c6", y, 8'h10);
    chk("en done c6", done, 1);
    @(negedge clk);
    chk("en y c7", y, 0);

    // Reset mid-DRIVE: outputs clear at once, no done follows.
    set_code(3'd6);
    hold     = 4'd10;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort y pre", y, 8'h40);
    rst_n = 1'b0;
    #1;
    chk("abort y", y, 0);
    chk("abort y_valid", y_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("abort no done", seen_done, 0);
    chk("abort y end", y, 0);
    chk("abort ready end", in_ready, 1);

`ifdef DEC_PARITY_EN
    // Bad parity: consumed, flagged, not driven.
    code     = 3'b011;
    code_par = 1'b0;
    hold     = 4'd4;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("par err c1", err, 1);
    chk("par y c1", y, 0);
    chk("par busy c1", busy, 0);
    @(negedge clk);
    chk("par err c2", err, 0);
    chk("par y c2", y, 0);
    chk("par ready c2", in_ready, 1);
    run_pulse(tbl[0], "par good");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_3x8_pulse.md
# decoder_3x8_pulse

Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a programmable output hold time. It is the receive-side counterpart of the 8x3 encoder family. It takes a 3-bit code, drives exactly one of eight output lines high for a requested number of clock cycles, then pulses `done`. It sits between a code source (encoder, sequencer or CPU register) and eight one-hot select/enable loads.

## Interface
Parameters:
- `HOLD_W`, default 4: width of the hold-count input; the maximum hold is 2^HOLD_W − 1 cycles.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable; gates acceptance of new codes only.
- `in_valid`  in  1  code source presents `code`/`hold`.
- `in_ready`  out  1  block can accept a code this cycle.
- `code`  in  3  binary code 0..7.
- `hold`  in  HOLD_W  output hold length in cycles; 0 is treated as 1.
- `y`  out  8  registered one-hot output; `y[code]` = 1 while driving.
- `y_valid`  out  1  high exactly while `y` is non-zero.
- `busy`  out  1  high in DRIVE.
- `done`  out  1  one-cycle pulse on the last DRIVE cycle.
- `code_par`  in  1  parity bit; exists only with `DEC_PARITY_EN`.
- `err`  out  1  one-cycle parity-error pulse; exists only with `DEC_PARITY_EN`.

## Operation
- The state machine has two states, IDLE and DRIVE, encoded in 1 bit.
- Reset values: state IDLE, `y` 8'h00, `y_valid` 0, `busy` 0, `done` 0, `err` 0, and the hold counter 0.
- `in_ready` = (state == IDLE) && `en`. It is combinational and has no dependency on `in_valid`.
- Accept = `in_valid` && `in_ready`.
- IDLE → DRIVE on accept:
  - latch `code`;
  - load the counter with max(`hold`, 1) − 1;
  - register `y` = 8'b1 << `code`.
- In DRIVE, `y` holds its value and the counter decrements each cycle.
- When the counter reaches 0 in DRIVE:
  - assert `done` that cycle;
  - on the next edge, go to IDLE and clear `y` to 0.
- No acceptance occurs in DRIVE; `in_ready` = 0 there. Back-to-back codes therefore have at least one IDLE cycle between them.
- `en` deasserted during DRIVE does not abort the pulse; it only blocks the next acceptance.
- `code` and `hold` are sampled only on the accept edge. Changes at any other time are ignored.
- The counter is exactly HOLD_W bits wide and never wraps, because it starts at most at 2^HOLD_W − 2.
- Asserting `rst_n` mid-DRIVE immediately clears `y`, `busy`, `done` and the state. No `done` is produced for the aborted pulse.

## Timing
- Accept at edge N: from edge N onward (cycle N+1), `y`, `y_valid` and `busy` are 1.
- They stay high for exactly max(`hold`, 1) cycles.
- `done` is high during the final of those cycles.
- `in_ready` returns high one cycle after `done` (if `en` = 1).
- Minimum code-to-code period is max(`hold`, 1) + 1 cycles.
- Outputs `y`, `y_valid`, `busy`, `done` and `err` are all registered, with no combinational input-to-output path. `in_ready` is the only exception (it depends on `en`).

## Configuration
- `DEC_PARITY_EN` defined:
  - Adds `code_par` and `err`.
  - Odd parity is required over {`code`, `code_par`}.
  - On an accept with a parity mismatch: the code is consumed, the state stays IDLE, `y` stays 0, and `err` pulses for 1 cycle (registered, in the cycle after accept).
- `DEC_PARITY_EN` undefined: neither port exists, and every accepted code is driven.

## Structure
- Shared package `decoder_pkg` contains:
  - the state enum (IDLE, DRIVE);
  - the constants `DEC_IN_W` = 3 and `DEC_OUT_W` = 8;
  - the function `onehot3` (code → 8-bit one-hot).
- One sub-module, `hold_counter`: a loadable HOLD_W down-counter with a `zero` flag. All other logic lives in the top module.

## Test plan
- Reset: hold `rst_n` = 0 and apply random inputs → `y` = 8'h00, `busy` = 0, `done` = 0, `in_ready` = 0 during reset. After release with `en` = 1, `in_ready` = 1.
- Single code: `code` = 3, `hold` = 4, one-cycle valid → `y` = 8'h08 for exactly 4 cycles starting the cycle after accept, `done` on the 4th cycle, then `y` = 0 and `in_ready` = 1.
- Hold zero / sweep: `hold` = 0 with `code` = 0..7 → each code yields exactly a 1-cycle `y` = 1<<code, with `done` coincident with it.
- Backpressure: hold `in_valid` = 1 continuously with `code` = 5 then 6, `hold` = 2 → the second code is accepted only after the first `done` plus one IDLE cycle, and `y` sequence is 0x20, 0x20, 0, 0x40, 0x40.
- Enable and reset abort: set `en` = 0 mid-DRIVE → the pulse completes normally and the next code is not accepted until `en` = 1. Separately, assert `rst_n` = 0 mid-DRIVE (`hold` = 10) → `y` clears immediately and no `done` occurs.
- Parity (`DEC_PARITY_EN`): `code` = 3'b011 with `code_par` = 0 → `err` pulses once and `y` stays 0. With `code_par` = 1 → `y` = 8'h08 normally.
